violation_reset_ctrl: RTL

Collects the per-monitor violation resets (DMA monitor, key-access monitor, atomicity monitor) and turns them into one clean, minimum-width reset request to the openMSP430 core. It retries the pulse if the monitors fail to release, and logs the cause of each violation. It sits directly downstream of the DMA detection monitor and its sibling monitors, and upstream of the core's reset input.

---
 rtl/violation_reset_ctrl_pkg.sv | 20 ++
 rtl/violation_reset_ctrl_timer.sv | 31 +++
 rtl/violation_reset_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/violation_reset_ctrl_pkg.sv
// Shared encodings for the violation reset controller.
// State codes, cause-bit indices and a timer-load helper.
package violation_reset_ctrl_pkg;

    localparam logic [1:0] ST_ARMED = 2'b00;
    localparam logic [1:0] ST_PULSE = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;

    localparam int CAUSE_DMA  = 0;
    localparam int CAUSE_KEY  = 1;
    localparam int CAUSE_ATOM = 2;

    localparam int TMR_W = 16;

    // Timer reload value for a phase lasting n cycles.
    function automatic logic [TMR_W-1:0] tmr_load(input int unsigned n);
        return TMR_W'(n - 1);
    endfunction

endpackage

// File: rtl/violation_reset_ctrl_timer.sv
// Loadable 16-bit down-counter shared by the pulse and timeout phases.
// Stops at zero; zero flag is decoded from the count register.
import violation_reset_ctrl_pkg::*;

module rst_pulse_timer #(
    parameter logic [TMR_W-1:0] RST_VAL = 16'd63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    logic [TMR_W-1:0] cnt_q;

    // Load has priority over decrement; count holds at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - TMR_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/violation_reset_ctrl.sv
// Merges monitor violation resets into one fixed-width core reset pulse.
// Optional cause/count logging is built when VIOL_LOG_EN is defined.
import violation_reset_ctrl_pkg::*;

module violation_reset_ctrl #(
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic             mclk,
    input  logic             por,
    input  logic             dma_reset,
    input  logic             key_reset,
    input  logic             atom_reset,
    input  logic             cause_clr,
    output logic             sys_reset,
    output logic             busy,
    output logic             release_timeout,
    output logic [2:0]       viol_cause,
    output logic [CNT_W-1:0] viol_count
);

    localparam logic [TMR_W-1:0] RST_LOAD = tmr_load(RST_CYCLES);
    localparam logic [TMR_W-1:0] TO_LOAD  = tmr_load(TIMEOUT_CYCLES);

    logic [2:0]       src_q;
    logic             any_q;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             tmr_load_en;
    logic             tmr_dec;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             arm;
    logic             fire;

    // Register monitor resets to break the pc-to-reset combinational loop.
    always_ff @(posedge mclk or posedge por) begin
        if (por) begin
            src_q <= '0;
        end else begin
            src_q[CAUSE_DMA]  <= dma_reset;
            src_q[CAUSE_KEY]  <= key_reset;
            src_q[CAUSE_ATOM] <= atom_reset;
        end
    end

    assign any_q = |src_q;

    rst_pulse_timer #(
        .RST_VAL (TO_LOAD)
    ) u_timer (
        .clk      (mclk),
        .rst      (por),
        .load     (tmr_load_en),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next-state and timer control.
    always_comb begin
        state_d     = state_q;
        tmr_load_en = 1'b0;
        tmr_dec     = 1'b0;
        tmr_val     = RST_LOAD;
        arm         = 1'b0;
        fire        = 1'b0;
        case (state_q)
            ST_ARMED: begin
                tmr_load_en = 1'b1;
                if (any_q) begin
                    state_d = ST_PULSE;
                    arm     = 1'b1;
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    state_d     = ST_WAIT;
                    tmr_load_en = 1'b1;
                    tmr_val     = TO_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!any_q) begin
                    state_d     = ST_ARMED;
                    tmr_load_en = 1'b1;
                end else if (tmr_zero) begin
                    state_d     = ST_PULSE;
                    tmr_load_en = 1'b1;
                    fire        = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d     = ST_WAIT;
                tmr_load_en = 1'b1;
                tmr_val     = TO_LOAD;
            end
        endcase
    end

    // State and registered outputs; power-up waits for monitors to release.
    always_ff @(posedge mclk or posedge por) begin
        if (por) begin
            state_q         <= ST_WAIT;
            sys_reset       <= 1'b0;
            release_timeout <= 1'b0;
        end else begin
            state_q         <= state_d;
            sys_reset       <= (state_d == ST_PULSE);
            release_timeout <= fire;
        end
    end

    assign busy = (state_q != ST_ARMED);

`ifdef VIOL_LOG_EN
    logic [2:0]       cause_q;
    logic [CNT_W-1:0] cnt_q;

    // Sticky causes; a new set beats a simultaneous clear.
    always_ff @(posedge mclk or posedge por) begin
        if (por) begin
            cause_q <= '0;
        end else if (arm) begin
            cause_q <= (cause_clr ? 3'b000 : cause_q) | src_q;
        end else if (cause_clr) begin
            cause_q <= '0;
        end
    end

    // Saturating violation counter, bumped on entry to the pulse.
    always_ff @(posedge mclk or posedge por) begin
        if (por) begin
            cnt_q <= '0;
        end else if (arm && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign viol_cause = cause_q;
    assign viol_count = cnt_q;
`else
    logic unused_log;

    assign unused_log = cause_clr | arm;
    assign viol_cause = '0;
    assign viol_count = '0;
`endif

endmodule
